master_bus_arbiter: RTL and testbench
=====================================

MASTER_BUS_ARBITER -- requirements
Module: master_bus_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_MASTERS, 2, number of masters (2..8).
- ROUND_ROBIN, 1, 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
- TIMEOUT_CYCLES, 0, maximum BUSY cycles without commonDone; 0 disables the timeout.
REQ-002 IDX_W SHALL be $clog2(NUM_MASTERS).
REQ-003 Ports SHALL be:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- masterReq  in  NUM_MASTERS  per-master request level.
- masterCmd  in  NUM_MASTERS x MemoryBusCmd  per-master command.
- masterResult  out  NUM_MASTERS x MemoryBusResult  per-master result.
- masterDone  out  NUM_MASTERS  per-master completion pulse.
- commonCmd  out  MemoryBusCmd  command to the shared slave bus.
- commonResult  in  MemoryBusResult  result from the shared bus.
- commonDone  in  1  slave completes the current transaction.
- grantValid  out  1  a master currently owns the bus.
- grantIdx  out  IDX_W  index of the owning master.
- timeoutErr  out  1  one-cycle pulse on timeout abort.

Function
REQ-004 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-005 In IDLE with any masterReq bit high at edge t, the block SHALL register the winner into grantIdx, set grantValid=1 and enter BUSY, all visible from cycle t+1.
REQ-006 ROUND_ROBIN=1: the winner SHALL be the first requesting index searching upward from rrPtr, wrapping from NUM_MASTERS-1 to 0.
REQ-007 ROUND_ROBIN=0: the winner SHALL be the lowest requesting index; rrPtr SHALL be ignored.
REQ-008 IDLE outputs SHALL be: commonCmd all-zero, every masterResult all-zero, masterDone all-zero, grantValid=0.
REQ-009 BUSY routing SHALL be:
- commonCmd = masterCmd[grantIdx].
- masterResult[grantIdx] = commonResult.
- All other masterResult entries all-zero.
REQ-010 BUSY with commonDone=1: masterDone[grantIdx]=1 combinationally in the same cycle; next state IDLE; rrPtr <= (grantIdx+1) mod NUM_MASTERS.
REQ-011 After every completion, at least one IDLE cycle SHALL occur before the next grant (one-cycle bubble).
REQ-012 In BUSY, grant SHALL hold regardless of masterReq changes; a dropped request SHALL NOT release the bus.
REQ-013 commonDone in IDLE SHALL be ignored.
REQ-014 Timeout counter: width $clog2(TIMEOUT_CYCLES+1); cleared on entry to BUSY; incremented on each BUSY cycle without commonDone.
REQ-015 TIMEOUT_CYCLES>0 and counter reaches TIMEOUT_CYCLES-1 in a BUSY cycle without commonDone: that cycle SHALL assert timeoutErr=1 and masterDone[grantIdx]=1 with masterResult[grantIdx] forced all-zero; next state IDLE; rrPtr advances as in REQ-010.
REQ-016 commonDone and the timeout condition in the same cycle: completion SHALL win, with timeoutErr=0 and the real result passed through.
REQ-017 At most one masterDone bit SHALL be high in any cycle.

Reset
REQ-018 rst=1 SHALL asynchronously force: state=IDLE, grantValid=0, grantIdx=0, rrPtr=0, counter=0, timeoutErr=0, masterDone=0, commonCmd all-zero.
REQ-019 Reset asserted mid-transaction SHALL abort it without any masterDone pulse.
REQ-020 The first arbitration SHALL occur at the first clock edge after rst deasserts.

Verification (NUM_MASTERS=4, ROUND_ROBIN=1, TIMEOUT_CYCLES=16 unless stated)
REQ-021 Single request: masterReq=4'b0100 at edge 0, commonDone at cycle 3 -> grantIdx=2 and grantValid=1 from cycle 1; masterDone=4'b0100 in cycle 3; IDLE in cycle 4.
REQ-022 Fairness: masterReq=4'b1111 held, commonDone 2 cycles after each grant -> grant order 0,1,2,3,0; exactly one IDLE cycle between grants.
REQ-023 Fixed priority (ROUND_ROBIN=0): masterReq=4'b1010 held -> every grant goes to index 1; index 3 is never granted.
REQ-024 Timeout: grant index 3 with no commonDone -> timeoutErr and masterDone=4'b1000 in the 16th BUSY cycle; masterResult[3]=0; next grant searches from index 0.
REQ-025 commonDone in the 16th BUSY cycle -> timeoutErr=0 and the result is passed through.
REQ-026 Routing/reset: in BUSY, commonCmd equals the granted masterCmd and non-granted masterResult=0; rst pulse mid-BUSY -> grantValid=0 immediately, no masterDone, and rrPtr=0 after release.

Source files
------------

// File: rtl/master_bus_arbiter.sv
// ============================================================================
// master_bus_arbiter : N-master to one-slave bus arbiter (round-robin/fixed)
// Revision: 1.0
// ============================================================================
`default_nettype none

module master_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CMD_W          = 32,
  parameter int RES_W          = 32,
  localparam int IDX_W         = $clog2(NUM_MASTERS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              masterReq,
  input  logic [NUM_MASTERS-1:0][CMD_W-1:0]   masterCmd,
  output logic [NUM_MASTERS-1:0][RES_W-1:0]   masterResult,
  output logic [NUM_MASTERS-1:0]              masterDone,
  output logic [CMD_W-1:0]                    commonCmd,
  input  logic [RES_W-1:0]                    commonResult,
  input  logic                                commonDone,
  output logic                                grantValid,
  output logic [IDX_W-1:0]                    grantIdx
  ,
  output logic                                timeoutErr
);

  localparam int                CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  C_TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [IDX_W:0]    C_NUM    = (IDX_W + 1)'(NUM_MASTERS);
  localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    grantIdx_q;
  logic [IDX_W-1:0]    rrPtr_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [IDX_W-1:0]    grantIdx_d;
  logic [IDX_W-1:0]    rrPtr_d;
  logic [IDX_W:0]      w_base;
  logic [IDX_W:0]      w_cand;
  logic                w_found;
  logic                w_busy;
  logic                w_tmo;
  logic                w_end;

  // Search upward from the base index with wrap; fixed priority always starts at 0.
  always_comb begin
    grantIdx_d = '0;
    w_found    = 1'b0;
    w_cand     = '0;
    w_base     = (ROUND_ROBIN != 0) ? {1'b0, rrPtr_q} : '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_cand = w_base + (IDX_W + 1)'(i);
      if (w_cand >= C_NUM) begin
        w_cand = w_cand - C_NUM;
      end
      if (!w_found && masterReq[w_cand[IDX_W-1:0]]) begin
        w_found    = 1'b1;
        grantIdx_d = w_cand[IDX_W-1:0];
      end
    end
  end

  assign rrPtr_d = (grantIdx_q == C_LAST_IDX) ? '0 : grantIdx_q + 1'b1;
  assign w_busy  = (state_q == BUSY);
  // A real completion in the same cycle takes precedence over the timeout.
  assign w_tmo   = (TIMEOUT_CYCLES > 0) && w_busy && !commonDone && (cnt_q == C_TMO_LAST);
  assign w_end   = w_busy && (commonDone || w_tmo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grantIdx_q <= '0;
      rrPtr_q    <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|masterReq) begin
            state_q    <= BUSY;
            grantIdx_q <= grantIdx_d;
            cnt_q      <= '0;
          end
        end
        BUSY: begin
          if (w_end) begin
            state_q <= IDLE;
            rrPtr_q <= rrPtr_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grantValid = w_busy;
  assign grantIdx   = grantIdx_q;
  assign timeoutErr = w_tmo;
  assign commonCmd  = w_busy ? masterCmd[grantIdx_q] : '0;

  always_comb begin
    masterDone   = '0;
    masterResult = '0;
    if (w_end) begin
      masterDone[grantIdx_q] = 1'b1;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_busy && !w_tmo && (grantIdx_q == IDX_W'(i))) begin
        masterResult[i] = commonResult;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_master_bus_arbiter.sv
// ============================================================================
// tb_master_bus_arbiter : directed self-checking bench for master_bus_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_master_bus_arbiter;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int RW = 16;

  logic                  clk;
  logic                  rst;
  logic [N-1:0]          masterReq;
  logic [N-1:0][CW-1:0]  masterCmd;
  logic [N-1:0][RW-1:0]  masterResult;
  logic [N-1:0]          masterDone;
  logic [CW-1:0]         commonCmd;
  logic [RW-1:0]         commonResult;
  logic                  commonDone;
  logic                  grantValid;
  logic [1:0]            grantIdx;
  logic                  timeoutErr;

  logic [N-1:0]          req2;
  logic [N-1:0][RW-1:0]  mres2;
  logic [N-1:0]          mdone2;
  logic [CW-1:0]         ccmd2;
  logic                  done2;
  logic                  gv2;
  logic [1:0]            gi2;
  logic                  tmo2;

  int total = 0;
  int bad   = 0;

  master_bus_arbiter #(
    .NUM_MASTERS(N), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(16), .CMD_W(CW), .RES_W(RW)
  ) u_rr (
    .clk(clk), .rst(rst), .masterReq(masterReq), .masterCmd(masterCmd),
    .masterResult(masterResult), .masterDone(masterDone), .commonCmd(commonCmd),
    .commonResult(commonResult), .commonDone(commonDone), .grantValid(grantValid),
    .grantIdx(grantIdx), .timeoutErr(timeoutErr)
  );

  master_bus_arbiter #(
    .NUM_MASTERS(N), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(16), .CMD_W(CW), .RES_W(RW)
  ) u_fp (
    .clk(clk), .rst(rst), .masterReq(req2), .masterCmd(masterCmd),
    .masterResult(mres2), .masterDone(mdone2), .commonCmd(ccmd2),
    .commonResult(commonResult), .commonDone(done2), .grantValid(gv2),
    .grantIdx(gi2), .timeoutErr(tmo2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    masterReq    = '0;
    req2         = '0;
    commonDone   = 1'b0;
    done2        = 1'b0;
    commonResult = 16'hBEEF;
    for (int i = 0; i < N; i++) masterCmd[i] = 16'hC000 + 16'(i);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grantValid", 64'(grantValid), 64'd0);
    chk("rst_grantIdx",   64'(grantIdx),   64'd0);
    chk("rst_commonCmd",  64'(commonCmd),  64'd0);
    chk("rst_masterDone", 64'(masterDone), 64'd0);
    chk("rst_timeoutErr", 64'(timeoutErr), 64'd0);

    // Single request from master 2
    rst       = 1'b0;
    masterReq = 4'b0100;
    #1;
    chk("pre_grant_idle", 64'(grantValid), 64'd0);
    cyc(); #1;
    chk("single_valid",  64'(grantValid), 64'd1);
    chk("single_idx",    64'(grantIdx),   64'd2);
    chk("single_cmd",    64'(commonCmd),  64'hC002);
    chk("single_result", 64'(masterResult), 64'h0000_BEEF_0000_0000);
    chk("single_nodone", 64'(masterDone), 64'd0);
    masterReq = '0;
    cyc(); #1;
    chk("hold_on_drop", 64'(grantValid), 64'd1);
    cyc();
    commonDone = 1'b1;
    #1;
    chk("single_done", 64'(masterDone), 64'b0100);
    cyc();
    commonDone = 1'b0;
    #1;
    chk("single_idle_valid",  64'(grantValid),   64'd0);
    chk("single_idle_cmd",    64'(commonCmd),    64'd0);
    chk("single_idle_result", 64'(masterResult), 64'd0);

    // rrPtr is 3 now: master 0 wins by wrap; then reset aborts mid-BUSY
    masterReq = 4'b0001;
    cyc(); #1;
    chk("wrap_idx", 64'(grantIdx), 64'd0);
    masterReq = '0;
    cyc();
    #2;
    rst        = 1'b1;
    commonDone = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(grantValid), 64'd0);
    chk("rst_mid_done",  64'(masterDone), 64'd0);
    chk("rst_mid_cmd",   64'(commonCmd),  64'd0);
    cyc();
    rst        = 1'b0;
    commonDone = 1'b0;
    masterReq  = 4'b1111;

    // Fairness: after reset rrPtr=0, so order is 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      chk("fair_valid", 64'(grantValid), 64'd1);
      chk("fair_idx",   64'(grantIdx),   64'(k % 4));
      cyc();
      cyc();
      commonDone = 1'b1;
      #1;
      chk("fair_done", 64'(masterDone), 64'(4'b0001 << (k % 4)));
      cyc();
      commonDone = 1'b0;
      #1;
      chk("fair_bubble", 64'(grantValid), 64'd0);
    end

    // Timeout on master 3
    masterReq    = 4'b1000;
    commonResult = 16'h1234;
    cyc(); #1;
    chk("tmo_idx", 64'(grantIdx), 64'd3);
    masterReq = '0;
    repeat (14) cyc();
    #1;
    chk("tmo_c15_err",  64'(timeoutErr), 64'd0);
    chk("tmo_c15_done", 64'(masterDone), 64'd0);
    cyc(); #1;
    chk("tmo_c16_err",    64'(timeoutErr),   64'd1);
    chk("tmo_c16_done",   64'(masterDone),   64'b1000);
    chk("tmo_c16_result", 64'(masterResult), 64'd0);
    masterReq = 4'b1001;
    cyc(); #1;
    chk("tmo_after_valid", 64'(grantValid), 64'd0);
    chk("tmo_after_err",   64'(timeoutErr), 64'd0);
    cyc(); #1;
    chk("tmo_next_idx", 64'(grantIdx), 64'd0);
    masterReq = '0;

    // Completion in the 16th BUSY cycle beats the timeout
    repeat (15) cyc();
    commonDone = 1'b1;
    #1;
    chk("race_err",    64'(timeoutErr),   64'd0);
    chk("race_done",   64'(masterDone),   64'b0001);
    chk("race_result", 64'(masterResult), 64'h0000_0000_0000_1234);
    cyc();
    #1;
    chk("idle_done_ignored", 64'(masterDone), 64'd0);
    cyc();
    commonDone = 1'b0;
    #1;
    chk("idle_done_novalid", 64'(grantValid), 64'd0);

    // Fixed priority instance: index 1 always beats index 3
    req2 = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("fp_valid", 64'(gv2), 64'd1);
      chk("fp_idx",   64'(gi2), 64'd1);
      cyc();
      done2 = 1'b1;
      #1;
      chk("fp_done", 64'(mdone2), 64'b0010);
      cyc();
      done2 = 1'b0;
      #1;
      chk("fp_bubble", 64'(gv2), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
